seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for the board's 8-digit common-anode 7-segment display (CA..CG, DP, AN).
//   Consumes hex values from the top level (counter values, status words) and drives the segment/anode pins.
//   Snapshots the value once per frame so a digit never mixes old and new data mid-scan.
//   Inserts a blanking gap between digits to suppress ghosting.
// PARAMETERS
//   NUM_DIGITS  8       digits scanned, 1..8; an width
//   DIGIT_CYC   100000  clk cycles each digit is lit, >=1 (1 ms at 100 MHz)
//   BLANK_CYC   1000    clk cycles all anodes off before each digit, >=1
// PORTS
//   clk        in   1              system clock
//   rst        in   1              synchronous reset, active-high
//   en         in   1              1 = scan display, 0 = display dark
//   value      in   4*NUM_DIGITS   hex nibbles; nibble i shown on digit i (digit 0 = rightmost)
//   dp_mask    in   NUM_DIGITS     1 = decimal point lit on digit i
//   blank_lz   in   1              1 = suppress leading zeros
//   seg        out  7              segments, active-low, seg[0]=CA .. seg[6]=CG
//   dp         out  1              decimal point, active-low
//   an         out  NUM_DIGITS     anode enables, active-low, one-hot-low when lit
//   frame_done out  1              1-cycle pulse on the last ON cycle of digit NUM_DIGITS-1
// BEHAVIOUR
//   - All outputs registered. Reset: state=OFF, seg=7'h7F, dp=1, an=all 1, frame_done=0, idx=0, pre=0.
//   - States: OFF, BLANK, ON. Prescaler pre, digit index idx, snapshot regs val_q/dp_q/lz_q.
//   - OFF: outputs dark. Next edge with en=1 -> BLANK, idx=0, pre=0, snapshot taken.
//   - BLANK: an all 1, seg=7'h7F, dp=1. pre counts 0..BLANK_CYC-1; at BLANK_CYC-1 -> ON, pre=0.
//   - ON: an[idx]=0 (others 1), seg=decode(val_q nibble idx), dp=~dp_q[idx]; pre counts 0..DIGIT_CYC-1.
//     At DIGIT_CYC-1 -> BLANK, pre=0, idx=idx+1; if idx==NUM_DIGITS-1, idx wraps to 0,
//     frame_done=1 for that cycle, and value/dp_mask/blank_lz re-snapshot on the same edge.
//   - Output timing: outputs change on the same edge as the state change; an goes low on the
//     first ON cycle and high on the first BLANK cycle. Each digit lit exactly DIGIT_CYC cycles.
//   - Frame period = NUM_DIGITS*(BLANK_CYC+DIGIT_CYC) cycles, constant; idx never skips.
//   - en=0 in any state: next edge -> OFF, outputs dark, idx=0, pre=0; frame_done not pulsed.
//   - rst mid-frame: same as reset values on the next edge, regardless of en.
//   - Leading zeros (lz_q=1): digit i blanked (an[i] stays 1 during its ON slot, timing unchanged)
//     when val_q nibbles i..NUM_DIGITS-1 are all zero and i!=0. Digit 0 is always shown.
//     A blanked digit's DP stays dark even if dp_q[i]=1.
//   - Hex decode (seg[6:0] = g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//     C=1000110 d=0100001 E=0000110 F=0001110.
//   - Changes to value mid-frame are not visible until the next frame boundary.
// TESTING  (bench params: NUM_DIGITS=8, DIGIT_CYC=4, BLANK_CYC=2; frame = 48 cycles)
//   1 Reset then en=1, value=32'h76543210 -> 2 dark cycles, an=8'hFE seg=7'b1000000 for 4 cycles,
//     2 dark, an=8'hFD seg=7'b1111001; frame_done pulses once per 48 cycles.
//   2 value=32'hFEDCBA98 -> digit 7 shows seg=7'b0001110, digit 0 shows 7'b0000000; full decode table checked.
//   3 blank_lz=1, value=32'h00000A05 -> an low only for digits 0,1,2; digits 3..7 slots dark;
//     value=0 -> only digit 0 lit, seg=7'b1000000.
//   4 Change value mid-frame (cycle 20) from 32'h11111111 to 32'h22222222 -> remaining digits of
//     the frame show 1; all digits show 2 from the next frame.
//   5 en=0 during digit 3 ON -> next cycle an=8'hFF, seg=7'h7F; en=1 -> restart at digit 0 after 2 BLANK cycles.
//   6 rst=1 mid-ON with en=1 -> next cycle all outputs at reset values, frame_done=0; dp_mask=8'h01 -> dp=0 only in digit 0 slot.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Snapshots value/dp_mask/blank_lz once per frame and inserts a blanking gap before each digit.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIGIT_CYC  = 100000,
  parameter int unsigned BLANK_CYC  = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned PRE_MAX = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int unsigned PRE_W   = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
  logic                    lz_q, lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    snap;
  logic                    hi_zero;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Scan sequencing: prescaler, digit index and per-frame snapshot.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dpm_d   = dpm_q;
    lz_d    = lz_q;
    snap    = 1'b0;

    if (!en) begin
      state_d = S_OFF;
      pre_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          pre_d   = '0;
          idx_d   = '0;
          snap    = 1'b1;
        end
        S_BLANK: begin
          if (pre_q == PRE_W'(BLANK_CYC - 1)) begin
            state_d = S_ON;
            pre_d   = '0;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        S_ON: begin
          if (pre_q == PRE_W'(DIGIT_CYC - 1)) begin
            state_d = S_BLANK;
            pre_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              snap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          pre_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    if (snap) begin
      val_d = value;
      dpm_d = dp_mask;
      lz_d  = blank_lz;
    end
  end

  // Digit select and leading-zero mask; snapshot is stable whenever state_d is ON.
  always_comb begin
    hi_zero   = 1'b1;
    lz_blank  = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero     = hi_zero & (val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_q & hi_zero & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        cur_nib   = val_q[4*i +: 4];
        cur_dp    = dpm_q[i];
        cur_blank = lz_blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // Outputs follow the next state so they switch on the same edge as the state.
  always_comb begin
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = (state_d == S_ON) && (pre_d == PRE_W'(DIGIT_CYC - 1)) &&
                   (idx_d == IDX_W'(NUM_DIGITS - 1));
    if (state_d == S_ON && !cur_blank) begin
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp;
      an_d  = an_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OFF;
      pre_q        <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      dpm_q        <= '0;
      lz_q         <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      dpm_q        <= dpm_d;
      lz_q         <= lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random stimulus, checked every cycle
// against a frame-position model (cycle t within a 48-cycle frame -> slot/phase arithmetic).
module tb_seg7_scan_driver;

  localparam int unsigned N     = 8;
  localparam int unsigned D     = 4;
  localparam int unsigned B     = 2;
  localparam int unsigned SLOT  = B + D;
  localparam int unsigned FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] value = 32'h0;
  logic [7:0]  dp_mask = 8'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [6:0] seg_tbl [16];

  // Reference model state
  bit          m_run;
  int          m_t;
  logic [31:0] m_val;
  logic [7:0]  m_dpm;
  bit          m_lz;

  seg7_scan_driver #(.NUM_DIGITS(N), .DIGIT_CYC(D), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    if (rst || !en) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
      m_val = value; m_dpm = dp_mask; m_lz = blank_lz;
    end else begin
      m_t++;
      if (m_t == int'(FRAME)) begin
        m_t   = 0;
        m_val = value; m_dpm = dp_mask; m_lz = blank_lz;
      end
    end
  endtask

  task automatic model_out(output logic [6:0] e_seg, output logic e_dp,
                           output logic [7:0] e_an, output logic e_fd);
    int slot, ph;
    logic [31:0] above;
    logic [3:0] nib;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 8'hFF; e_fd = 1'b0;
    if (m_run) begin
      slot  = m_t / int'(SLOT);
      ph    = m_t % int'(SLOT);
      above = m_val >> (4 * slot);
      nib   = above[3:0];
      e_fd  = (m_t == int'(FRAME) - 1);
      if (ph >= int'(B) && !(m_lz && slot != 0 && above == 32'h0)) begin
        e_an  = ~(8'h01 << slot);
        e_seg = seg_tbl[nib];
        e_dp  = ~m_dpm[slot];
      end
    end
  endtask

  task automatic step();
    logic [6:0] e_seg; logic e_dp; logic [7:0] e_an; logic e_fd;
    @(posedge clk);
    model_edge();
    #1;
    model_out(e_seg, e_dp, e_an, e_fd);
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Step until the model reaches frame position t (bounded).
  task automatic run_to(input int t);
    int guard = 0;
    while (!(m_run && m_t == t) && guard < 4 * int'(FRAME)) begin
      step();
      guard++;
    end
    check("run_to_timeout", 32'(guard < 4 * int'(FRAME)), 32'd1);
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_run = 1'b0; m_t = 0; m_val = '0; m_dpm = '0; m_lz = 1'b0;

    // 1: reset values, then basic scan; exactly two frame_done pulses in two frames
    rst = 1'b1;
    run(3);
    rst = 1'b0; en = 1'b1; value = 32'h76543210;
    fd_cnt = 0;
    run(2 * FRAME);
    check("fd_per_two_frames", 32'(fd_cnt), 32'd2);

    // 2: high hex digits, then every nibble value over two frames
    value = 32'hFEDCBA98;
    run(2 * FRAME);
    value = 32'h76543210;
    run(FRAME);

    // 3: leading-zero suppression
    blank_lz = 1'b1; value = 32'h00000A05;
    run(2 * FRAME);
    value = 32'h0;
    run(2 * FRAME);
    blank_lz = 1'b0;

    // 4: mid-frame value change not visible until next frame
    value = 32'h11111111;
    run_to(0);
    run(20);
    value = 32'h22222222;
    run(2 * FRAME);

    // 5: en dropped during digit 3 ON, then restart
    run_to(3 * SLOT + B + 1);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(FRAME);

    // 6: reset mid-ON with en held, decimal point on digit 0 only
    dp_mask = 8'h01;
    run_to(2 * SLOT + B + 2);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * FRAME);

    // Random stimulus
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        value    = $urandom >> (4 * $urandom_range(0, 8));
        dp_mask  = 8'($urandom);
        blank_lz = 1'($urandom);
      end
      en  = ($urandom_range(0, 99) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
